// File: rtl/demux_deser8_pkg.sv
// Shared definitions for the 8:1 serializer / 1:8 deserializer pair of the calculator datapath.
// Word width, select width, word type and the collector state encoding live here.
package demux_deser8_pkg;

    localparam int WORD_W = 8;
    localparam int SEL_W  = 3;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/demux1to8.sv
// 1-to-W demux: one-hot write mask for slot sel, plus d steered into that slot.
// Both outputs are zero when en is low.
module demux1to8
    import demux_deser8_pkg::*;
#(
    parameter int W  = WORD_W,
    parameter int SW = SEL_W
) (
    input  logic          d,
    input  logic [SW-1:0] sel,
    input  logic          en,
    output logic [W-1:0]  mask,
    output logic [W-1:0]  data
);

    always_comb begin
        mask = '0;
        data = '0;
        if (en) begin
            mask[sel] = 1'b1;
            data[sel] = d;
        end
    end

endmodule

// File: rtl/demux_deser8.sv
// Serial-to-parallel receiver: bits are steered into a shadow word by a position counter,
// and each completed word is handed to a valid/ready holding register.
module demux_deser8
    import demux_deser8_pkg::*;
#(
    parameter int WIDTH     = WORD_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       din,
    input  logic                       din_valid,
    input  logic                       sof,
    input  logic                       ovr_clr,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic [$clog2(WIDTH)-1:0]   sel_idx,
    output logic                       overrun
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    function automatic logic [CW-1:0] slot_of(input logic [CW-1:0] c);
        return MSB_FIRST ? (LAST - c) : c;
    endfunction

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n, eff_cnt;
    logic [WIDTH-1:0] shadow, shadow_n, base;
    logic [WIDTH-1:0] wmask, wdata;
    logic [WIDTH-1:0] dout_r;
    logic             dv, ovr;
    logic             complete, load, drop;

    // sof realigns before the write, so a bit arriving with sof lands in the first slot
    assign eff_cnt = sof ? '0 : cnt;
    assign base    = (eff_cnt == '0) ? '0 : shadow;

    demux1to8 #(.W(WIDTH), .SW(CW)) u_demux (
        .d    (din),
        .sel  (slot_of(eff_cnt)),
        .en   (din_valid),
        .mask (wmask),
        .data (wdata)
    );

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        shadow_n = shadow;
        complete = 1'b0;
        if (din_valid) begin
            cnt_n    = (eff_cnt == LAST) ? '0 : eff_cnt + 1'b1;
            shadow_n = (base & ~wmask) | wdata;
            complete = (eff_cnt == LAST);
        end else if (sof) begin
            cnt_n    = '0;
            shadow_n = '0;
        end
        case (state)
            IDLE:    if (din_valid && !complete) state_n = COLLECT;
            COLLECT: if (complete || (sof && !din_valid)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign load = complete && (!dv || dout_ready);
    assign drop = complete && dv && !dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            dout_r <= '0;
            dv     <= 1'b0;
            ovr    <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            shadow <= shadow_n;
            if (load) begin
                dout_r <= shadow_n;
                dv     <= 1'b1;
            end else if (dv && dout_ready) begin
                dv <= 1'b0;
            end
            // a drop in the same cycle as ovr_clr keeps the flag set
            if (drop)         ovr <= 1'b1;
            else if (ovr_clr) ovr <= 1'b0;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dv;
    assign overrun    = ovr;
    assign sel_idx    = slot_of(cnt);

endmodule

// File: doc/demux_deser8.md
Name: demux_deser8

Overview:
- Serial-to-parallel receiver; the opposite end of the 8:1 bit-select path used by the serializer side of the calculator datapath.
- Accepts one bit per valid cycle. A 3-bit position counter drives a 1-to-8 demux that steers each bit into its slot of a shadow word.
- A completed word moves into an output holding register with a valid/ready handshake.
- Feeds 8-bit operands to the calculator core.

Parameters:
- WIDTH, 8, word width in bits; the counter width is derived as clog2(WIDTH) = 3.
- MSB_FIRST, 0, bit order: 0 = first accepted bit goes to bit 0; 1 = first accepted bit goes to bit WIDTH-1.

Ports:
- clk  input  1  rising-edge clock, the single clock domain.
- rst  input  1  synchronous reset, active-high; sampled on the clk rising edge.
- din  input  1  serial data bit.
- din_valid  input  1  din is accepted this cycle.
- sof  input  1  start-of-frame; realigns the position counter to 0.
- ovr_clr  input  1  clears the sticky overrun flag.
- dout  output  8  assembled word, stable while dout_valid=1.
- dout_valid  output  1  holding register contains an unconsumed word.
- dout_ready  input  1  consumer accepts dout this cycle when dout_valid=1.
- sel_idx  output  3  current demux slot, i.e. the position the next bit will fill.
- overrun  output  1  sticky flag: a completed word was dropped.

Behaviour:
- Reset (rst=1 at a clk edge), overriding all other inputs that cycle:
  - state=IDLE, counter=0, shadow=0x00.
  - dout=0x00, dout_valid=0, overrun=0, sel_idx=0.
- FSM states: IDLE (counter=0, no partial word) and COLLECT (1..7 bits held).
- Transitions:
  - IDLE to COLLECT on an accepted bit.
  - COLLECT to IDLE when bit 7 of the word is accepted, or on sof without din_valid.
- Slot mapping: slot = counter when MSB_FIRST=0; slot = 7 - counter when MSB_FIRST=1.
  - sel_idx always shows the slot the next accepted bit will fill.
- Accepted bit (din_valid=1):
  - The demux one-hot enable writes din into shadow[slot].
  - The counter increments and wraps 7 to 0.
- Shadow clearing: slots not yet written in the current word read 0. The shadow is cleared when a word starts, i.e. on an accepted bit while counter=0.
- sof=1 with din_valid=1: the bit is written to the first slot, counter goes to 1, and any partial word is discarded (its other bits are cleared).
- sof=1 with din_valid=0: counter goes to 0, shadow is cleared, state goes to IDLE.
- Word completion happens when the 8th bit is accepted (counter=7, din_valid=1). The full word, including this bit, is offered to the holding register:
  - Holding register empty, or dout_ready=1 the same cycle: dout loads the word and dout_valid=1 from the next cycle.
  - dout_valid=1 and dout_ready=0: the new word is dropped, dout is unchanged, overrun is set next cycle. Collection continues at counter=0.
- Handshake:
  - dout_valid=1 and dout_ready=1 with no completion that cycle: dout_valid=0 next cycle and dout holds its last value.
  - dout and dout_valid never change while dout_valid=1 and dout_ready=0.
- Latency: dout_valid rises 1 cycle after the last bit is accepted. A continuous stream gives 1 word per 8 cycles with no gaps.
- Overrun:
  - Set by a dropped word.
  - Cleared by ovr_clr. If ovr_clr and a drop occur in the same cycle, set wins.
- din and sof are ignored only when rst=1.

Decomposition:
- Shared package, also used by the serializer:
  - constants WORD_W=8 and SEL_W=3;
  - a typedef for the 8-bit word;
  - a typedef for the state enum {IDLE, COLLECT}.
- Sub-module demux1to8: inputs d, sel[2:0], en; output 8-bit one-hot write mask qualified by en; purely combinational.
- The top level holds the counter, FSM, shadow register, holding register and overrun logic.

Test Plan:
- Reset: assert rst with din_valid=1 and sof=1 -> next cycle dout=0x00, dout_valid=0, overrun=0, sel_idx=0.
- LSB-first word: MSB_FIRST=0, sof on the first bit, bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles, dout_ready=1 -> dout=0xA5 and dout_valid=1 exactly 1 cycle after the 8th bit, then 0 the following cycle.
- MSB-first word: MSB_FIRST=1, the same bit stream -> dout=0xA5 (bits written to 7..0).
- Backpressure and overrun:
  - dout_ready=0; stream 0x3C, then 0xC3 -> dout stays 0x3C, overrun=1 the cycle after the 16th bit.
  - Then assert ovr_clr -> overrun=0.
  - Then raise dout_ready -> dout_valid falls the next cycle.
- Realign: send 3 bits, pulse sof without din_valid, then 8 bits of 0x0F -> dout=0x0F; the partial bits never appear.
- Simultaneous completion and ready: dout_valid=1 with 0x11 while the last bit of 0x22 arrives and dout_ready=1 in the same cycle -> dout=0x22 next cycle, dout_valid stays 1, overrun=0.
